// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: entry record, PC step sizes, canonical NOP.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        compressed;
  } fq_entry_t;

  localparam int unsigned PC_STEP_C = 2;
  localparam int unsigned PC_STEP_W = 4;
  localparam logic [31:0] INST_NOP  = 32'h00000013;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry array for the fetch queue; pointers are owned by the parent.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [PW-1:0]   wr_ptr,
  input  fq_entry_t       wr_data,
  input  logic [PW-1:0]   rd_ptr,
  output fq_entry_t       rd_data
);

  fq_entry_t mem [DEPTH];

  // Data array carries no reset; validity is tracked by the parent's count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-PC owner and instruction queue between realigner and decode.
// Optional same-cycle bypass of an empty queue is enabled by defining FQ_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fe_pc,
  output logic        fe_stall,
  output logic        fe_step,
  output logic        fe_flush,
  input  logic        fe_ready,
  input  logic [31:0] fe_inst,
  input  logic        fe_compressed,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_pc,
  output logic [31:0] deq_inst,
  output logic        deq_compressed
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_r;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic      full;
  logic      empty;
  logic      enq_fire;
  logic      wr_en;
  logic      pop;
  logic      byp_take;
  fq_entry_t wr_data;
  fq_entry_t rd_data;
  fq_entry_t head;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign enq_fire = fe_ready & ~full & ~redirect_valid & ~rst;

  assign fe_pc    = pc_r;
  assign fe_step  = enq_fire;
  assign fe_stall = ~enq_fire;
  assign fe_flush = redirect_valid;

  assign wr_data = '{pc: pc_r, inst: fe_inst, compressed: fe_compressed};

`ifdef FQ_BYPASS_EN
  logic byp;
  // An empty queue forwards the incoming instruction straight to decode.
  assign byp       = empty & enq_fire;
  assign deq_valid = (~empty | byp) & ~redirect_valid;
  assign head      = byp ? wr_data : rd_data;
  assign byp_take  = byp & deq_ready;
`else
  assign deq_valid = ~empty & ~redirect_valid;
  assign head      = rd_data;
  assign byp_take  = 1'b0;
`endif

  // Storage is popped only for a real stored entry, never for a bypassed one.
  assign pop   = ~empty & ~redirect_valid & deq_ready;
  assign wr_en = enq_fire & ~byp_take;

  assign deq_pc         = head.pc;
  assign deq_inst       = head.inst;
  assign deq_compressed = head.compressed;

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r   <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc_r   <= redirect_pc & ~32'h1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) pc_r <= pc_r + (fe_compressed ? 32'(PC_STEP_C) : 32'(PC_STEP_W));
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table plus randomized run against a queue model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fe_pc;
  logic        fe_stall, fe_step, fe_flush;
  logic        fe_ready;
  logic [31:0] fe_inst;
  logic        fe_compressed;
  logic        deq_valid, deq_ready;
  logic [31:0] deq_pc, deq_inst;
  logic        deq_compressed;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fe_pc(fe_pc), .fe_stall(fe_stall), .fe_step(fe_step), .fe_flush(fe_flush),
    .fe_ready(fe_ready), .fe_inst(fe_inst), .fe_compressed(fe_compressed),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_inst(deq_inst), .deq_compressed(deq_compressed)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, rv; logic [31:0] rp;
    logic fr; logic [31:0] fi; logic fc; logic dr;
    logic [31:0] e_pc; logic e_step, e_flush, e_dv;
    logic [31:0] e_dpc, e_dinst; logic e_dc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rp,
                     input logic fr, input logic [31:0] fi, input logic fc, input logic dr,
                     input logic [31:0] e_pc, input logic e_step, input logic e_flush,
                     input logic e_dv, input logic [31:0] e_dpc, input logic [31:0] e_dinst,
                     input logic e_dc);
    vec_t v;
    v.rst = r; v.rv = rv; v.rp = rp; v.fr = fr; v.fi = fi; v.fc = fc; v.dr = dr;
    v.e_pc = e_pc; v.e_step = e_step; v.e_flush = e_flush; v.e_dv = e_dv;
    v.e_dpc = e_dpc; v.e_dinst = e_dinst; v.e_dc = e_dc;
    tbl.push_back(v);
  endtask

  // Behavioural model: a plain queue of entries plus a PC
  fq_entry_t mq[$];
  logic [31:0] pc_m;

  task automatic model_cycle();
    int sz;
    logic enq, byp, dv;
    fq_entry_t hd;
    sz  = mq.size();
    enq = fe_ready && (sz != DEPTH) && !redirect_valid && !rst;
`ifdef FQ_BYPASS_EN
    byp = (sz == 0) && enq;
`else
    byp = 1'b0;
`endif
    dv = ((sz != 0) || byp) && !redirect_valid;
    hd = byp ? '{pc: pc_m, inst: fe_inst, compressed: fe_compressed} : ((sz != 0) ? mq[0] : '0);
    #3;
    chk("rnd_fe_pc", fe_pc, pc_m);
    chk("rnd_fe_step", {31'd0, fe_step}, {31'd0, enq});
    chk("rnd_fe_stall", {31'd0, fe_stall}, {31'd0, !enq});
    chk("rnd_fe_flush", {31'd0, fe_flush}, {31'd0, redirect_valid});
    chk("rnd_deq_valid", {31'd0, deq_valid}, {31'd0, dv});
    if (dv) begin
      chk("rnd_deq_pc", deq_pc, hd.pc);
      chk("rnd_deq_inst", deq_inst, hd.inst);
      chk("rnd_deq_c", {31'd0, deq_compressed}, {31'd0, hd.compressed});
    end
    @(posedge clk);
    if (rst) begin
      mq.delete(); pc_m = RESET_PC;
    end else if (redirect_valid) begin
      mq.delete(); pc_m = {redirect_pc[31:1], 1'b0};
    end else begin
      if (!(byp && deq_ready)) begin
        if (dv && deq_ready) void'(mq.pop_front());
        if (enq) mq.push_back('{pc: pc_m, inst: fe_inst, compressed: fe_compressed});
      end
      if (enq) pc_m = pc_m + (fe_compressed ? 32'd2 : 32'd4);
    end
    #1;
  endtask

  localparam logic [31:0] A0 = 32'h00100093, A1 = 32'h00200113, A2 = 32'h00300193,
                          A3 = 32'h00400213, A4 = 32'h00500293;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; fe_ready = 1'b0;
    fe_inst = '0; fe_compressed = 1'b0; deq_ready = 1'b0;

    //   rst rv rp            fr fi            fc dr  e_pc          stp fl dv dpc           dinst         dc
    add(1, 0, 0,            1, 32'h13,       0, 0,  32'h0,        0, 0, 0, 0,           0,            0);
    add(0, 0, 0,            1, 32'h13,       0, 1,  32'h0,        1, 0, 0, 0,           0,            0);
    add(0, 0, 0,            1, 32'h4501,     1, 1,  32'h4,        1, 0, 1, 32'h0,       32'h13,       0);
    add(0, 0, 0,            1, 32'h100093,   0, 1,  32'h6,        1, 0, 1, 32'h4,       32'h4501,     1);
    add(0, 0, 0,            0, 0,            0, 1,  32'hA,        0, 0, 1, 32'h6,       32'h100093,   0);
    add(0, 0, 0,            0, 0,            0, 0,  32'hA,        0, 0, 0, 0,           0,            0);
    add(0, 1, 32'h0,        1, 0,            0, 0,  32'hA,        0, 1, 0, 0,           0,            0);
    add(0, 0, 0,            1, A0,           0, 0,  32'h0,        1, 0, 0, 0,           0,            0);
    add(0, 0, 0,            1, A1,           0, 0,  32'h4,        1, 0, 1, 32'h0,       A0,           0);
    add(0, 0, 0,            1, A2,           0, 0,  32'h8,        1, 0, 1, 32'h0,       A0,           0);
    add(0, 0, 0,            1, A3,           0, 0,  32'hC,        1, 0, 1, 32'h0,       A0,           0);
    add(0, 0, 0,            1, A4,           0, 0,  32'h10,       0, 0, 1, 32'h0,       A0,           0);
    add(0, 0, 0,            1, A4,           0, 1,  32'h10,       0, 0, 1, 32'h0,       A0,           0);
    add(0, 0, 0,            1, A4,           0, 0,  32'h10,       1, 0, 1, 32'h4,       A1,           0);
    add(0, 0, 0,            0, 0,            0, 0,  32'h14,       0, 0, 1, 32'h4,       A1,           0);
    add(0, 0, 0,            0, 0,            0, 1,  32'h14,       0, 0, 1, 32'h4,       A1,           0);
    add(0, 1, 32'h101,      1, A0,           0, 1,  32'h14,       0, 1, 0, 0,           0,            0);
    add(0, 0, 0,            0, 0,            0, 1,  32'h100,      0, 0, 0, 0,           0,            0);
    add(0, 0, 0,            0, 0,            0, 1,  32'h100,      0, 0, 0, 0,           0,            0);
    add(0, 0, 0,            0, 0,            0, 1,  32'h100,      0, 0, 0, 0,           0,            0);
    add(0, 1, 32'hFFFFFFFC, 0, 0,            0, 0,  32'h100,      0, 1, 0, 0,           0,            0);
    add(0, 0, 0,            1, 32'h13,       0, 0,  32'hFFFFFFFC, 1, 0, 0, 0,           0,            0);
    add(0, 0, 0,            0, 0,            0, 0,  32'h0,        0, 0, 1, 32'hFFFFFFFC, 32'h13,      0);
    add(0, 0, 0,            0, 0,            0, 1,  32'h0,        0, 0, 1, 32'hFFFFFFFC, 32'h13,      0);
    add(0, 0, 0,            0, 0,            0, 1,  32'h0,        0, 0, 0, 0,           0,            0);

    @(posedge clk); #1;

`ifndef FQ_BYPASS_EN
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rp;
      fe_ready = tbl[i].fr; fe_inst = tbl[i].fi; fe_compressed = tbl[i].fc;
      deq_ready = tbl[i].dr;
      #3;
      chk($sformatf("v%0d_fe_pc", i), fe_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_fe_step", i), {31'd0, fe_step}, {31'd0, tbl[i].e_step});
      chk($sformatf("v%0d_fe_stall", i), {31'd0, fe_stall}, {31'd0, !tbl[i].e_step});
      chk($sformatf("v%0d_fe_flush", i), {31'd0, fe_flush}, {31'd0, tbl[i].e_flush});
      chk($sformatf("v%0d_deq_valid", i), {31'd0, deq_valid}, {31'd0, tbl[i].e_dv});
      if (tbl[i].e_dv) begin
        chk($sformatf("v%0d_deq_pc", i), deq_pc, tbl[i].e_dpc);
        chk($sformatf("v%0d_deq_inst", i), deq_inst, tbl[i].e_dinst);
        chk($sformatf("v%0d_deq_c", i), {31'd0, deq_compressed}, {31'd0, tbl[i].e_dc});
      end
      @(posedge clk); #1;
    end
`endif

    // Reset into a known state for the model-checked phase
    rst = 1'b1; redirect_valid = 1'b0; fe_ready = 1'b0; deq_ready = 1'b0;
    @(posedge clk); #1;
    mq.delete(); pc_m = RESET_PC;

    // Empty-queue latency with decode ready: bypass-dependent, checked by the model
    rst = 1'b0; fe_ready = 1'b1; fe_inst = INST_NOP; fe_compressed = 1'b0; deq_ready = 1'b1;
    model_cycle();
    fe_ready = 1'b0;
    model_cycle();
    model_cycle();

    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 | 32'($urandom_range(0, 7))
                                                   : $urandom;
      fe_ready       = ($urandom_range(0, 9) < 7);
      fe_inst        = $urandom;
      fe_compressed  = (fe_inst[1:0] != 2'b11);
      deq_ready      = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 2));
      model_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
